// File: rtl/mac_rx_pkg.sv
// Shared constants, FSM state type and helpers for the multi-slot receive MAC.
package mac_rx_pkg;

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [7:0]  PREAMBLE    = 8'h55;
    localparam logic [7:0]  SFD         = 8'hD5;
    localparam int          MIN_FRAME   = 64;
    localparam logic [47:0] BCAST       = 48'hFFFFFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_DATA,
        ST_DROP,
        ST_COMMIT
    } rx_state_t;

    // Register is kept MSB-aligned while data bits enter LSB first, so a clean
    // frame plus its FCS leaves the well-known residue in the register.
    function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 8; i++) begin
            r = (r[31] ^ data[i]) ? ((r << 1) ^ CRC_POLY) : (r << 1);
        end
        return r;
    endfunction

    // Byte idx of a MAC address in wire order (idx 0 is the most significant byte).
    function automatic logic [7:0] mac_byte(input logic [47:0] addr, input logic [2:0] idx);
        return addr[47 - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/mac_crc32_d8.sv
// Byte-wide Ethernet CRC32 register with clock enable and synchronous init.
module mac_crc32_d8
    import mac_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (reset || init) begin
            crc <= 32'hFFFFFFFF;
        end else if (en) begin
            crc <= crc32_d8(crc, data);
        end
    end

endmodule

// File: rtl/mac_rx_nbuf.sv
// MII/GMII receive MAC: SFD hunt, per-frame checks, N-slot circular frame buffer
// with a random-access read port on the head slot and explicit slot release.
//
// state  | meaning
// IDLE   | waiting for RXDV
// HUNT   | scanning preamble for the SFD, bounded by a symbol timer
// DATA   | storing bytes into the write slot; evaluated on RXDV fall
// DROP   | frame rejected, waiting for RXDV to fall before counting it
// COMMIT | latch length, advance write slot, count the good frame
module mac_rx_nbuf
    import mac_rx_pkg::*;
#(
    parameter int          DATA_W     = 4,
    parameter int          SLOTS      = 4,
    parameter int          SLOT_DEPTH = 2048,
    parameter logic [47:0] MAC_ADDR   = 48'h000A35000001,
    parameter bit          FILTER_EN  = 1'b1,
    parameter bit          CHECK_CRC  = 1'b1
) (
    input  logic                          PHY_RXC,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             PHY_RXD,
    input  logic                          PHY_RXDV,
    input  logic                          PHY_RXER,
    input  logic                          Rd_en,
    input  logic [$clog2(SLOT_DEPTH)-1:0] Rd_Addr,
    output logic [7:0]                    Rd_data,
    output logic                          Frm_valid,
    output logic [$clog2(SLOT_DEPTH):0]   Frm_len,
    input  logic                          Frm_done,
    output logic [15:0]                   Good_cnt,
    output logic [15:0]                   Drop_cnt
);

    localparam int AW        = $clog2(SLOT_DEPTH);
    localparam int SW        = $clog2(SLOTS);
    localparam int HUNT_SYMS = (DATA_W == 8) ? 16 : 32;

    localparam logic [AW:0] HDR_END = (AW + 1)'(6);
    localparam logic [AW:0] MIN_LEN = (AW + 1)'(MIN_FRAME);
    localparam logic [AW:0] OVF_LEN = (AW + 1)'(SLOT_DEPTH);
    localparam logic [SW:0] FULL    = (SW + 1)'(SLOTS);

    rx_state_t   state, state_nxt;
    logic [7:0]  mem [SLOTS*SLOT_DEPTH];
    logic [AW:0] len_tbl [SLOTS];
    logic [AW:0] offset;
    logic [SW-1:0] wr_slot, rd_slot;
    logic [SW:0] occ;
    logic [5:0]  hunt_tmr;
    logic [3:0]  prev_nib, low_nib;
    logic        nib_phase, ucast_ok, bcast_ok;
    logic [31:0] crc_q;

    logic [7:0]  rx_sym, byte_val;
    logic        sfd_hit, byte_rdy, byte_we, frame_start, frame_bad;
    logic        cnt_good, cnt_drop, frame_rel;

    always_comb begin
        rx_sym    = 8'(PHY_RXD);
        sfd_hit   = (DATA_W == 8) ? (rx_sym == SFD)
                                  : (prev_nib == PREAMBLE[3:0] && rx_sym[3:0] == SFD[7:4]);
        byte_val  = (DATA_W == 8) ? rx_sym : {rx_sym[3:0], low_nib};
        byte_rdy  = (DATA_W == 8) || nib_phase;
        frame_rel = Frm_done && (occ != '0);
        frame_bad = (offset < MIN_LEN)
                 || (DATA_W == 4 && nib_phase)
                 || (CHECK_CRC && crc_q != CRC_RESIDUE)
                 || (FILTER_EN && !(ucast_ok || bcast_ok))
                 || (occ == FULL);
    end

    always_ff @(posedge PHY_RXC) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        byte_we     = 1'b0;
        frame_start = 1'b0;
        cnt_good    = 1'b0;
        cnt_drop    = 1'b0;
        case (state)
            ST_IDLE: if (PHY_RXDV) state_nxt = ST_HUNT;
            ST_HUNT: begin
                if (!PHY_RXDV) begin
                    state_nxt = ST_IDLE;
                end else if (sfd_hit) begin
                    state_nxt   = ST_DATA;
                    frame_start = 1'b1;
                end else if (hunt_tmr == '0) begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!PHY_RXDV) begin
                    state_nxt = frame_bad ? ST_IDLE : ST_COMMIT;
                    cnt_drop  = frame_bad;
                end else if (PHY_RXER || (byte_rdy && offset == OVF_LEN)) begin
                    // a byte arriving with the slot already full overflows it
                    state_nxt = ST_DROP;
                end else begin
                    byte_we = byte_rdy;
                end
            end
            ST_DROP: begin
                if (!PHY_RXDV) begin
                    state_nxt = ST_IDLE;
                    cnt_drop  = 1'b1;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
                cnt_good  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    mac_crc32_d8 u_crc (
        .clk   (PHY_RXC),
        .reset (reset),
        .init  (frame_start),
        .en    (byte_we),
        .data  (byte_val),
        .crc   (crc_q)
    );

    always_ff @(posedge PHY_RXC) begin
        if (reset) begin
            offset    <= '0;
            wr_slot   <= '0;
            rd_slot   <= '0;
            occ       <= '0;
            hunt_tmr  <= '0;
            prev_nib  <= '0;
            low_nib   <= '0;
            nib_phase <= 1'b0;
            ucast_ok  <= 1'b0;
            bcast_ok  <= 1'b0;
            Good_cnt  <= '0;
            Drop_cnt  <= '0;
            for (int i = 0; i < SLOTS; i++) len_tbl[i] <= '0;
        end else begin
            prev_nib <= rx_sym[3:0];
            if (state == ST_IDLE)      hunt_tmr <= 6'(HUNT_SYMS - 2);
            else if (hunt_tmr != '0)   hunt_tmr <= hunt_tmr - 1'b1;

            if (frame_start) begin
                offset    <= '0;
                nib_phase <= 1'b0;
                ucast_ok  <= 1'b1;
                bcast_ok  <= 1'b1;
            end else if (state == ST_DATA && PHY_RXDV && !PHY_RXER) begin
                nib_phase <= (DATA_W == 4) ? ~nib_phase : 1'b0;
                if (!nib_phase) low_nib <= rx_sym[3:0];
                if (byte_we) begin
                    offset <= offset + 1'b1;
                    if (offset < HDR_END) begin
                        ucast_ok <= ucast_ok && (byte_val == mac_byte(MAC_ADDR, offset[2:0]));
                        bcast_ok <= bcast_ok && (byte_val == mac_byte(BCAST, offset[2:0]));
                    end
                end
            end

            if (state == ST_COMMIT) begin
                len_tbl[wr_slot] <= offset;
                wr_slot          <= wr_slot + 1'b1;
            end
            if (frame_rel) rd_slot <= rd_slot + 1'b1;

            case ({state == ST_COMMIT, frame_rel})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (cnt_good && Good_cnt != 16'hFFFF) Good_cnt <= Good_cnt + 1'b1;
            if (cnt_drop && Drop_cnt != 16'hFFFF) Drop_cnt <= Drop_cnt + 1'b1;
        end
    end

    always_ff @(posedge PHY_RXC) begin
        if (byte_we) mem[{wr_slot, offset[AW-1:0]}] <= byte_val;
    end

    always_ff @(posedge PHY_RXC) begin
        if (reset)      Rd_data <= '0;
        else if (Rd_en) Rd_data <= mem[{rd_slot, Rd_Addr}];
    end

    assign Frm_valid = (occ != '0);
    assign Frm_len   = len_tbl[rd_slot];

endmodule

// File: tb/tb_mac_rx_nbuf.sv
// Directed bench: MII default build, MII build without FCS check, GMII build.
module tb_mac_rx_nbuf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic [10:0] rd_addr = '0;

    logic [3:0]  rxd0 = '0, rxd1 = '0;
    logic [7:0]  rxd2 = '0;
    logic        rxdv0 = 0, rxdv1 = 0, rxdv2 = 0;
    logic        rxer0 = 0, rxer1 = 0, rxer2 = 0;
    logic        done0 = 0, done1 = 0, done2 = 0;
    logic [7:0]  rdat0, rdat1, rdat2;
    logic        fv0, fv1, fv2;
    logic [11:0] flen0, flen1, flen2;
    logic [15:0] good0, good1, good2, drop0, drop1, drop2;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] frm [$];

    always #5 clk = ~clk;

    mac_rx_nbuf #(.DATA_W(4)) dut0 (
        .PHY_RXC(clk), .reset(reset), .PHY_RXD(rxd0), .PHY_RXDV(rxdv0), .PHY_RXER(rxer0),
        .Rd_en(rd_en), .Rd_Addr(rd_addr), .Rd_data(rdat0), .Frm_valid(fv0), .Frm_len(flen0),
        .Frm_done(done0), .Good_cnt(good0), .Drop_cnt(drop0));

    mac_rx_nbuf #(.DATA_W(4), .CHECK_CRC(1'b0)) dut1 (
        .PHY_RXC(clk), .reset(reset), .PHY_RXD(rxd1), .PHY_RXDV(rxdv1), .PHY_RXER(rxer1),
        .Rd_en(rd_en), .Rd_Addr(rd_addr), .Rd_data(rdat1), .Frm_valid(fv1), .Frm_len(flen1),
        .Frm_done(done1), .Good_cnt(good1), .Drop_cnt(drop1));

    mac_rx_nbuf #(.DATA_W(8)) dut2 (
        .PHY_RXC(clk), .reset(reset), .PHY_RXD(rxd2), .PHY_RXDV(rxdv2), .PHY_RXER(rxer2),
        .Rd_en(rd_en), .Rd_Addr(rd_addr), .Rd_data(rdat2), .Frm_valid(fv2), .Frm_len(flen2),
        .Frm_done(done2), .Good_cnt(good2), .Drop_cnt(drop2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame of total_len bytes (FCS included); FCS from the reflected CRC32.
    task automatic build(input logic [47:0] da, input int total_len);
        logic [31:0] c;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'(8'h10 + i));
        frm.push_back(8'h08);
        frm.push_back(8'h00);
        for (int i = 14; i < total_len - 4; i++) frm.push_back(8'(i * 7 + 3));
        c = 32'hFFFFFFFF;
        foreach (frm[i]) begin
            c = c ^ {24'h0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
    endtask

    task automatic drive(input int ch, input logic [7:0] d, input logic dv, input logic er);
        @(negedge clk);
        case (ch)
            0: begin rxd0 = d[3:0]; rxdv0 = dv; rxer0 = er; end
            1: begin rxd1 = d[3:0]; rxdv1 = dv; rxer1 = er; end
            default: begin rxd2 = d; rxdv2 = dv; rxer2 = er; end
        endcase
    endtask

    task automatic mii_send(input int ch, input int nbytes, input bit close);
        for (int i = 0; i < 20; i++) drive(ch, (i < 4) ? 8'h0F : ((i < 19) ? 8'h05 : 8'h0D), 1, 0);
        for (int i = 0; i < nbytes; i++) begin
            drive(ch, {4'h0, frm[i][3:0]}, 1, 0);
            drive(ch, {4'h0, frm[i][7:4]}, 1, 0);
        end
        if (close) drive(ch, 8'h00, 0, 0);
    endtask

    task automatic gmii_send(input int er_at);
        for (int i = 0; i < 7; i++) drive(2, 8'h55, 1, 0);
        drive(2, 8'hD5, 1, 0);
        foreach (frm[i]) drive(2, frm[i], 1, (i == er_at));
        drive(2, 8'h00, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done(input int ch);
        @(negedge clk);
        case (ch) 0: done0 = 1; 1: done1 = 1; default: done2 = 1; endcase
        @(negedge clk);
        done0 = 0; done1 = 0; done2 = 0;
    endtask

    task automatic rd(input logic [10:0] a);
        @(negedge clk);
        rd_en = 1; rd_addr = a;
        @(negedge clk);
        rd_en = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        check("rst_rd_data", rdat0, 0);
        check("rst_frm_valid", fv0, 0);
        check("rst_frm_len", flen0, 0);
        check("rst_good", good0, 0);
        check("rst_drop", drop0, 0);
        reset = 0;
        idle(2);

        // Good broadcast frame, minimum length
        build(48'hFFFFFFFFFFFF, 64);
        mii_send(0, 64, 1);
        idle(2);
        check("bc_valid_2cyc", fv0, 1);
        check("bc_len", flen0, 64);
        check("bc_good", good0, 1);
        for (int i = 0; i < 6; i++) begin
            rd(11'(i));
            check("bc_da_ff", rdat0, 8'hFF);
        end
        rd(11'd12);
        check("bc_type", rdat0, 8'h08);
        pulse_done(0);
        check("bc_released", fv0, 0);

        // Corrupted payload bit: dropped with CRC check, kept without
        build(48'hFFFFFFFFFFFF, 64);
        frm[20] = frm[20] ^ 8'h01;
        mii_send(0, 64, 1);
        idle(4);
        check("badcrc_valid", fv0, 0);
        check("badcrc_drop", drop0, 1);
        mii_send(1, 64, 1);
        idle(4);
        check("nocrc_valid", fv1, 1);
        check("nocrc_good", good1, 1);
        check("nocrc_len", flen1, 64);

        // Address filter
        build(48'h000A35000002, 64);
        mii_send(0, 64, 1);
        idle(4);
        check("uc_other_valid", fv0, 0);
        check("uc_other_drop", drop0, 2);
        build(48'h000A35000001, 64);
        mii_send(0, 64, 1);
        idle(4);
        check("uc_own_valid", fv0, 1);
        check("uc_own_len", flen0, 64);
        check("uc_own_good", good0, 2);
        rd(11'd5);
        check("uc_own_da5", rdat0, 8'h01);
        pulse_done(0);

        // Five frames into four slots
        for (int f = 0; f < 5; f++) begin
            build(48'hFFFFFFFFFFFF, 64 + f);
            mii_send(0, 64 + f, 1);
            idle(4);
        end
        check("full_good", good0, 6);
        check("full_drop", drop0, 3);
        check("full_len0", flen0, 64);
        for (int k = 1; k <= 4; k++) begin
            pulse_done(0);
            check("drain_valid", fv0, (k < 4) ? 1 : 0);
            if (k < 4) check("drain_len", flen0, 32'(64 + k));
        end

        // Release coinciding with a commit while two frames are held
        build(48'hFFFFFFFFFFFF, 64);
        mii_send(0, 64, 1);
        idle(4);
        build(48'hFFFFFFFFFFFF, 70);
        mii_send(0, 70, 1);
        idle(4);
        build(48'hFFFFFFFFFFFF, 72);
        mii_send(0, 72, 1);
        pulse_done(0);
        idle(2);
        check("coinc_valid", fv0, 1);
        check("coinc_len", flen0, 70);
        check("coinc_good", good0, 9);
        pulse_done(0);
        check("coinc_occ2_valid", fv0, 1);
        check("coinc_len_next", flen0, 72);
        pulse_done(0);
        check("coinc_empty", fv0, 0);

        // Reset in the middle of a frame, then a clean frame
        build(48'hFFFFFFFFFFFF, 80);
        mii_send(0, 20, 0);
        @(negedge clk);
        reset = 1;
        idle(2);
        rxdv0 = 0;
        reset = 0;
        idle(2);
        build(48'hFFFFFFFFFFFF, 66);
        mii_send(0, 66, 1);
        idle(3);
        check("rstmid_good", good0, 1);
        check("rstmid_drop", drop0, 0);
        check("rstmid_len", flen0, 66);
        rd(11'd0);
        check("rstmid_slot0", rdat0, 8'hFF);

        // GMII build
        build(48'hFFFFFFFFFFFF, 64);
        gmii_send(-1);
        idle(3);
        check("gmii_valid", fv2, 1);
        check("gmii_len", flen2, 64);
        check("gmii_good", good2, 1);
        rd(11'd63);
        check("gmii_last", rdat2, {24'h0, frm[63]});
        gmii_send(30);
        idle(3);
        check("gmii_rxer_drop", drop2, 1);
        check("gmii_rxer_good", good2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
